// File: rtl/alu_control_sequencer_pkg.sv
// cpu_ctrl_pkg: control-step states, ALU opcodes and IR field positions for alu_control_sequencer
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T5U, T5M, T6, RETIRE} state_t;
  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
  function automatic logic is_binary(input logic [OP_W-1:0] op);
    return (op >= OP_ADD && op <= OP_ROL) || is_muldiv(op);
  endfunction
  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return op == OP_NEG || op == OP_NOT;
  endfunction
endpackage

// File: rtl/alu_control_sequencer_reg_sel_decoder.sv
// reg_sel_decoder: register index plus enable to one-hot vector, zero for out-of-range indices
module reg_sel_decoder #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]    sel_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);
  always_comb onehot_o = (en_i && 32'(sel_i) < NUM_REGS) ? NUM_REGS'(1) << sel_i : '0;
endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: fetch/execute control-step sequencer; ALU_SEQ_SINGLE_STEP_EN adds a single-step input
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_SEL_W = 4,
  parameter int OPCODE_W = 5,
  parameter int IR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
`ifdef ALU_SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic                pc_out,
  output logic                mar_enable,
  output logic                pc_increment,
  output logic                read,
  output logic                mdr_enable,
  output logic                mdr_out,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                lo_enable,
  output logic                hi_enable,
  output logic [OPCODE_W-1:0] op_code,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                illegal,
  output logic                busy,
  output logic [CNT_W-1:0]    instr_count
);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic go, again, bin, un, alu_t3;
  logic [OPCODE_W-1:0] op;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic unused_ir;
`ifdef ALU_SEQ_SINGLE_STEP_EN
  assign go = run && step;
  assign again = 1'b0;
`else
  assign go = run;
  assign again = run;
`endif
  assign op = ir[OP_LSB +: OPCODE_W];
  assign ra = ir[RA_LSB +: REG_SEL_W];
  assign rb = ir[RB_LSB +: REG_SEL_W];
  assign rc = ir[RC_LSB +: REG_SEL_W];
  assign unused_ir = ^ir[RC_LSB-1:0];
  assign bin = is_binary(op);
  assign un = is_unary(op);
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= go ? T0 : IDLE;
        T0: state_q <= T1;
        T1: state_q <= mem_ready ? T2 : T1;
        T2: state_q <= T3;
        T3: state_q <= bin ? T4 : un ? T5U : RETIRE;
        T4: state_q <= is_muldiv(op) ? T5M : T5;
        T5, T5U, T6: state_q <= RETIRE;
        T5M: state_q <= T6;
        RETIRE: begin
          cnt_q <= cnt_q + 1'b1;
          state_q <= again ? T0 : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Unary ops collapse operand read and ALU strobe into T3, so both share the z_enable/op_code path with T4
  assign alu_t3 = state_q == T3 && un;
  assign pc_out = state_q == T0;
  assign mar_enable = state_q == T0;
  assign pc_increment = state_q == T0;
  assign read = state_q == T1;
  assign mdr_enable = state_q == T1;
  assign mdr_out = state_q == T2;
  assign ir_enable = state_q == T2;
  assign y_enable = state_q == T3 && bin;
  assign z_enable = alu_t3 || state_q == T4;
  assign zlo_out = state_q inside {T1, T5, T5U, T5M};
  assign zhi_out = state_q == T6;
  assign lo_enable = state_q == T5M;
  assign hi_enable = state_q == T6;
  assign op_code = (alu_t3 || state_q == T4) ? op : '0;
  assign illegal = state_q == T3 && !bin && !un;
  assign busy = state_q != IDLE;
  assign instr_count = cnt_q;
  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_out_dec (
    .sel_i(state_q == T4 ? rc : rb),
    .en_i((state_q == T3 && (bin || un)) || state_q == T4),
    .onehot_o(reg_out)
  );
  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_en_dec (
    .sel_i(ra),
    .en_i(state_q == T5 || state_q == T5U),
    .onehot_o(reg_enable)
  );
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: scoreboard bench comparing per-cycle control vectors against a spec-derived trace
module tb_alu_control_sequencer;
  logic clk = 1'b0;
  logic clr, run, mem_ready;
  logic [31:0] ir;
`ifdef ALU_SEQ_SINGLE_STEP_EN
  logic step;
`endif
  logic pc_out, mar_enable, pc_increment, read, mdr_enable, mdr_out, ir_enable;
  logic y_enable, z_enable, zlo_out, zhi_out, lo_enable, hi_enable, illegal, busy;
  logic [4:0] op_code;
  logic [15:0] reg_out, reg_enable;
  logic [31:0] instr_count;
  logic [51:0] obs;
  typedef struct {
    logic [51:0] v;
    logic mr;
    string tag;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 0;
  localparam logic [14:0] C_PC = 15'h4000, C_MAR = 15'h2000, C_PCI = 15'h1000, C_RD = 15'h0800;
  localparam logic [14:0] C_MDRE = 15'h0400, C_MDRO = 15'h0200, C_IRE = 15'h0100, C_Y = 15'h0080;
  localparam logic [14:0] C_Z = 15'h0040, C_ZLO = 15'h0020, C_ZHI = 15'h0010, C_LO = 15'h0008;
  localparam logic [14:0] C_HI = 15'h0004, C_ILL = 15'h0002, C_BUSY = 15'h0001;

  alu_control_sequencer dut (
    .clk(clk), .clr(clr), .run(run),
`ifdef ALU_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .mar_enable(mar_enable), .pc_increment(pc_increment), .read(read),
    .mdr_enable(mdr_enable), .mdr_out(mdr_out), .ir_enable(ir_enable), .y_enable(y_enable),
    .z_enable(z_enable), .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_enable(lo_enable),
    .hi_enable(hi_enable), .op_code(op_code), .reg_out(reg_out), .reg_enable(reg_enable),
    .illegal(illegal), .busy(busy), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  assign obs = {pc_out, mar_enable, pc_increment, read, mdr_enable, mdr_out, ir_enable, y_enable,
                z_enable, zlo_out, zhi_out, lo_enable, hi_enable, illegal, busy, op_code, reg_out, reg_enable};

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra, rb, rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [51:0] o, input logic [51:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag);
    checks++;
    assert (instr_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s: observed count %0d expected %0d", tag, instr_count, exp_cnt);
    end
  endtask

  task automatic push(input logic [14:0] c, input logic [4:0] op, input logic [15:0] ro,
                      input logic [15:0] re, input logic mr, input string tag);
    q.push_back('{v: {c | C_BUSY, op, ro, re}, mr: mr, tag: tag});
  endtask

  // Spec-level expectation for one instruction starting in T0
  task automatic load(input logic [31:0] i, input int waits);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic bin, md, un;
    op = i[31:27]; ra = i[26:23]; rb = i[22:19]; rc = i[18:15];
    md = op == 5'b01111 || op == 5'b10000;
    bin = (op >= 5'b00011 && op <= 5'b01011) || md;
    un = op == 5'b10001 || op == 5'b10010;
    push(C_PC | C_MAR | C_PCI, 0, 0, 0, 1'b1, "T0");
    for (int w = 0; w <= waits; w++) push(C_RD | C_MDRE | C_ZLO, 0, 0, 0, w == waits, "T1");
    push(C_MDRO | C_IRE, 0, 0, 0, 1'b1, "T2");
    if (bin) begin
      push(C_Y, 0, oh(rb), 0, 1'b1, "T3_bin");
      push(C_Z, op, oh(rc), 0, 1'b1, "T4");
      if (md) begin
        push(C_ZLO | C_LO, 0, 0, 0, 1'b1, "T5M");
        push(C_ZHI | C_HI, 0, 0, 0, 1'b1, "T6");
      end else push(C_ZLO, 0, 0, oh(ra), 1'b1, "T5");
    end else if (un) begin
      push(C_Z, op, oh(rb), 0, 1'b1, "T3_un");
      push(C_ZLO, 0, 0, oh(ra), 1'b1, "T5U");
    end else push(C_ILL, 0, 0, 0, 1'b1, "T3_ill");
    push(0, 0, 0, 0, 1'b1, "RETIRE");
  endtask

  // Pops one expectation per cycle; abort_at >= 0 asserts clr after that entry
  task automatic drain(input logic hold, input int abort_at);
    exp_t e;
    int k;
    k = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.mr;
      check(e.tag, obs, e.v);
      if (k == 0 && !hold) run = 1'b0;
      if (k == abort_at) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        q.delete();
        exp_cnt = 0;
        return;
      end
      tick();
      k++;
    end
    exp_cnt++;
  endtask

  task automatic start();
    run = 1'b1;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    tick();
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
  endtask

  task automatic one(input string tag, input logic [31:0] i, input int waits);
    ir = i;
    start();
    load(i, waits);
    drain(1'b0, -1);
    check_cnt({tag, "_count"});
    check({tag, "_idle"}, obs, 52'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = '0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick();
    tick();
    clr = 1'b0;
    check("reset_outputs", obs, 52'h0);
    check_cnt("reset_count");
    tick();
    check("idle_hold", obs, 52'h0);
    one("not_r5_r0", mk_ir(5'b10010, 4'd5, 4'd0, 4'd0), 0);
    one("add_r4_r9_r4", mk_ir(5'b00011, 4'd4, 4'd9, 4'd4), 0);
    one("mul_r3_r0", mk_ir(5'b01111, 4'd3, 4'd3, 4'd0), 0);
    one("and_memwait", mk_ir(5'b00101, 4'd15, 4'd1, 4'd14), 3);
    one("illegal_11111", mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), 0);
    one("neg_r7_r7", mk_ir(5'b10001, 4'd7, 4'd7, 4'd0), 0);
    one("rol_r0_r12_r6", mk_ir(5'b01011, 4'd0, 4'd12, 4'd6), 1);
    ir = mk_ir(5'b10000, 4'd1, 4'd8, 4'd10);
    start();
    load(ir, 0);
    drain(1'b1, -1);
    check_cnt("div_hold_count");
`ifdef ALU_SEQ_SINGLE_STEP_EN
    check("single_step_idle", obs, 52'h0);
    tick();
    check("single_step_wait", obs, 52'h0);
    ir = mk_ir(5'b00100, 4'd11, 4'd2, 4'd13);
    start();
`else
    ir = mk_ir(5'b00100, 4'd11, 4'd2, 4'd13);
`endif
    load(ir, 0);
    drain(1'b0, -1);
    check_cnt("sub_b2b_count");
    check("sub_b2b_idle", obs, 52'h0);
    ir = mk_ir(5'b00011, 4'd4, 4'd9, 4'd4);
    start();
    load(ir, 0);
    drain(1'b0, 4);
    check("clr_mid_t4_outputs", obs, 52'h0);
    check_cnt("clr_mid_t4_count");
    tick();
    check("clr_mid_t4_stays_idle", obs, 52'h0);
    one("or_after_clr", mk_ir(5'b00110, 4'd6, 4'd5, 4'd4), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
